// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage plus the IF/ID pipeline register.
//
// Keeps the fetch address and drives a request/ready handshake to the
// instruction memory. It handles hazard-unit stalls with a one-entry skid
// buffer and EX-stage redirects. A redirect that arrives while a request is
// still in flight goes through a SQUASH state: the address is not dropped
// until the memory has answered, and that stale answer is then thrown away.
//
// Ports:
//   CLK, RESET            clock; asynchronous active-high reset
//   IMEM_REQ/ADDR         fetch request to instruction memory
//   IMEM_READY/RDATA      memory completion and instruction word
//   STALL                 hold IF/ID contents
//   BRANCH_TAKEN/TARGET   one-cycle redirect pulse and its target
//   INSTRUCTION, PC,      IF/ID register outputs; invalid slots carry a NOP
//   PC_PLUS4, VALID
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_READY,
  input  logic [31:0] IMEM_RDATA,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic        VALID
);

  // REQ: requesting ADDR. SQUASH: requesting ADDR, response to be dropped.
  // HOLD: skid buffer full, no request outstanding.
  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  logic        handshake;
  logic [31:0] target;
  logic        load;
  logic [31:0] load_instr;
  logic [31:0] load_pc;

  assign IMEM_REQ  = ((state_q == ST_REQ) || (state_q == ST_SQUASH)) && !RESET;
  assign IMEM_ADDR = addr_q;
  assign handshake = IMEM_REQ && IMEM_READY;
  // Targets are always word aligned.
  assign target    = BRANCH_TARGET & ~32'h3;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pend_tgt_d   = pend_tgt_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    load         = 1'b0;
    load_instr   = IMEM_RDATA;
    load_pc      = addr_q;

    case (state_q)
      ST_REQ: begin
        if (BRANCH_TAKEN) begin
          if (handshake) begin
            addr_d = target;
          end else begin
            // The request in flight must still complete; remember the target.
            pend_tgt_d = target;
            state_d    = ST_SQUASH;
          end
        end else if (handshake) begin
          addr_d = addr_q + 32'd4;
          if (STALL) begin
            skid_instr_d = IMEM_RDATA;
            skid_pc_d    = addr_q;
            state_d      = ST_HOLD;
          end else begin
            load = 1'b1;
          end
        end
      end
      ST_SQUASH: begin
        if (handshake) begin
          addr_d  = BRANCH_TAKEN ? target : pend_tgt_q;
          state_d = ST_REQ;
        end else if (BRANCH_TAKEN) begin
          pend_tgt_d = target;
        end
      end
      ST_HOLD: begin
        if (BRANCH_TAKEN) begin
          addr_d  = target;
          state_d = ST_REQ;
        end else if (!STALL) begin
          load       = 1'b1;
          load_instr = skid_instr_q;
          load_pc    = skid_pc_q;
          state_d    = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    // IF/ID update: flush beats stall, stall beats load, else a bubble.
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (BRANCH_TAKEN) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (STALL) begin
      valid_d = valid_q;
    end else if (load) begin
      valid_d    = 1'b1;
      instr_d    = load_instr;
      pc_d       = load_pc;
      pc_plus4_d = load_pc + 32'd4;
    end else begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_REQ;
      addr_q       <= RESET_PC;
      pend_tgt_q   <= 32'h0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= 32'h0;
      instr_q      <= NOP_INSTR;
      pc_q         <= 32'h0;
      pc_plus4_q   <= 32'h0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pend_tgt_q   <= pend_tgt_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      pc_plus4_q   <= pc_plus4_d;
      valid_q      <= valid_d;
    end
  end

  assign INSTRUCTION = instr_q;
  assign PC          = pc_q;
  assign PC_PLUS4    = pc_plus4_q;
  assign VALID       = valid_q;

endmodule
